// File: rtl/round_timer_pkg.sv
// Shared definitions for the round countdown timer: state encoding,
// BCD digit width and default limits.
package round_timer_pkg;

  localparam int DIGIT_W      = 4;
  localparam int DEF_MAX_SEC  = 99;
  localparam int DEF_WARN_SEC = 5;
  localparam int TICK_PER_SEC = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

endpackage

// File: rtl/round_timer_bcd_down_digit.sv
// One BCD (or radix-RADIX) down-counting digit with synchronous clear/load
// and a borrow-out when a decrement wraps 0 -> RADIX-1.
module bcd_down_digit
  import round_timer_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow
);

  logic [DIGIT_W-1:0] digit_d, digit_q;

  // Next digit value: clear beats load beats decrement.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = load_val;
    end else if (dec) begin
      digit_d = (digit_q == '0) ? DIGIT_W'(RADIX - 1) : digit_q - DIGIT_W'(1);
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign borrow = dec && (digit_q == '0);

endmodule

// File: rtl/round_timer.sv
// Per-round countdown timer: loads whole seconds, counts down in tenths on
// the 100 ms tick, shows BCD digits and pulses time_up at 00.0.
// Optional low-time warning output enabled by defining ROUND_TIMER_WARN_EN.
//
// state      | meaning
// ST_IDLE    | no round active, digits hold last value (00.0)
// ST_RUN     | counting down on each tick
// ST_PAUSED  | round frozen while pause is high
// ST_EXPIRED | single cycle after reaching 00.0, drives time_up
module round_timer
  import round_timer_pkg::*;
#(
  parameter int MAX_SEC = DEF_MAX_SEC
`ifdef ROUND_TIMER_WARN_EN
  , parameter int WARN_SEC = DEF_WARN_SEC
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Time_out_100ms,
  input  logic               start,
  input  logic [6:0]         load_sec,
  input  logic               pause,
  input  logic               abort,
  output logic               busy,
  output logic               time_up,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] tenths
`ifdef ROUND_TIMER_WARN_EN
  , output logic             warn
`endif
);

  state_t             state_d, state_q;
  logic               busy_d, busy_q;
  logic               time_up_d, time_up_q;
  logic               dig_clr, dig_load, tick_dec;
  logic [6:0]         sat_sec;
  logic [DIGIT_W-1:0] load_tens, load_ones;
  logic               last_tenth;
  logic               tenths_borrow, ones_borrow;
  // Tens never borrows: expiry is taken on the tick leaving 00.1.
  logic               tens_borrow_unused;

  // Saturate the requested length and split it into BCD with a compare ladder.
  always_comb begin
    sat_sec   = (int'(load_sec) > MAX_SEC) ? 7'(MAX_SEC) : load_sec;
    load_tens = '0;
    for (int k = 1; k <= 9; k++) begin
      if (int'(sat_sec) >= 10 * k) load_tens = DIGIT_W'(k);
    end
    load_ones = DIGIT_W'(int'(sat_sec) - 10 * int'(load_tens));
  end

  assign last_tenth = (sec_tens == '0) && (sec_ones == '0) && (tenths == DIGIT_W'(1));

  // Next state and digit controls; abort > start > pause > tick.
  always_comb begin
    state_d  = state_q;
    dig_clr  = 1'b0;
    dig_load = 1'b0;
    tick_dec = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      dig_clr = 1'b1;
    end else if (start) begin
      dig_load = 1'b1;
      state_d  = (sat_sec == '0) ? ST_EXPIRED : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (Time_out_100ms) begin
            tick_dec = 1'b1;
            if (last_tenth) state_d = ST_EXPIRED;
          end
        end
        ST_PAUSED:  if (!pause) state_d = ST_RUN;
        ST_EXPIRED: state_d = ST_IDLE;
        default:    state_d = state_q;
      endcase
    end
    busy_d    = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    time_up_d = (state_d == ST_EXPIRED);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      time_up_q <= time_up_d;
    end
  end

  assign busy    = busy_q;
  assign time_up = time_up_q;

  bcd_down_digit #(.RADIX(TICK_PER_SEC)) u_tenths (
    .clk(clk), .rst(rst), .clr(dig_clr), .load(dig_load), .load_val('0),
    .dec(tick_dec), .digit(tenths), .borrow(tenths_borrow)
  );

  bcd_down_digit #(.RADIX(10)) u_ones (
    .clk(clk), .rst(rst), .clr(dig_clr), .load(dig_load), .load_val(load_ones),
    .dec(tenths_borrow), .digit(sec_ones), .borrow(ones_borrow)
  );

  bcd_down_digit #(.RADIX(10)) u_tens (
    .clk(clk), .rst(rst), .clr(dig_clr), .load(dig_load), .load_val(load_tens),
    .dec(ones_borrow), .digit(sec_tens), .borrow(tens_borrow_unused)
  );

`ifdef ROUND_TIMER_WARN_EN
  logic warn_d, warn_q;
  int   sec_now, sec_nxt;

  // Whole seconds as they will be after this cycle, compared against the threshold.
  always_comb begin
    sec_now = 10 * int'(sec_tens) + int'(sec_ones);
    if (dig_clr)                            sec_nxt = 0;
    else if (dig_load)                      sec_nxt = int'(sat_sec);
    else if (tick_dec && (tenths == '0))    sec_nxt = sec_now - 1;
    else                                    sec_nxt = sec_now;
    warn_d = busy_d && (sec_nxt < WARN_SEC);
  end

  // Warning register, updates together with the digits.
  always_ff @(posedge clk) begin
    if (rst) warn_q <= 1'b0;
    else     warn_q <= warn_d;
  end

  assign warn = warn_q;
`endif

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer: constant vector table, directed
// corner sequences and randomized stimulus against a tenths-count model.
module tb_round_timer;
  import round_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1, tick = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [6:0] load_sec = '0;
  logic       busy, time_up;
  logic [3:0] sec_tens, sec_ones, tenths;
`ifdef ROUND_TIMER_WARN_EN
  logic       warn;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: remaining time as an integer number of tenths.
  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXP} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_rem  = 0;
  localparam int LIMIT_SEC = 99;
  localparam int WARN_LIM  = 5;

  always #5 clk = ~clk;

  round_timer dut (
    .clk(clk), .rst(rst), .Time_out_100ms(tick), .start(start),
    .load_sec(load_sec), .pause(pause), .abort(abort),
    .busy(busy), .time_up(time_up),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .tenths(tenths)
`ifdef ROUND_TIMER_WARN_EN
    , .warn(warn)
`endif
  );

  typedef struct {
    bit r, t, s; int ld; bit p, a;
    bit e_busy, e_tu; int e_tens, e_ones, e_tenths;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, t, s, input int ld, input bit p, a);
    if (r) begin
      m_mode = M_IDLE; m_rem = 0;
    end else if (a) begin
      m_mode = M_IDLE; m_rem = 0;
    end else if (s) begin
      m_rem  = ((ld > LIMIT_SEC) ? LIMIT_SEC : ld) * 10;
      m_mode = (m_rem == 0) ? M_EXP : M_RUN;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (p) m_mode = M_PAUSED;
          else if (t) begin
            m_rem--;
            if (m_rem == 0) m_mode = M_EXP;
          end
        end
        M_PAUSED: if (!p) m_mode = M_RUN;
        M_EXP:    m_mode = M_IDLE;
        default:  ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
  task automatic step(input bit r, t, s, input int ld, input bit p, a);
    rst = r; tick = t; start = s; load_sec = 7'(ld); pause = p; abort = a;
    @(posedge clk);
    model_step(r, t, s, ld, p, a);
    #1;
  endtask

  task automatic cyc(input bit r, t, s, input int ld, input bit p, a);
    step(r, t, s, ld, p, a);
    chk("busy",    int'(busy),    int'(m_mode == M_RUN || m_mode == M_PAUSED));
    chk("time_up", int'(time_up), int'(m_mode == M_EXP));
    chk("digits",  100 * int'(sec_tens) + 10 * int'(sec_ones) + int'(tenths), m_rem);
`ifdef ROUND_TIMER_WARN_EN
    chk("warn", int'(warn),
        int'((m_mode == M_RUN || m_mode == M_PAUSED) && (m_rem / 10 < WARN_LIM)));
`endif
  endtask

  function automatic int shown();
    return 100 * int'(sec_tens) + 10 * int'(sec_ones) + int'(tenths);
  endfunction

  initial begin
    vec_t tbl[$];
    int   tu_cnt, tu_at, n;
    bit   p_lvl;

    //        r  t  s  ld  p  a  busy tu tens ones tnth
    tbl.push_back('{1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1,   3, 0, 0, 1, 0, 0, 3, 0});
    tbl.push_back('{0, 1, 0,   0, 0, 0, 1, 0, 0, 2, 9});
    tbl.push_back('{0, 1, 0,   0, 1, 0, 1, 0, 0, 2, 9});
    tbl.push_back('{0, 1, 0,   0, 1, 0, 1, 0, 0, 2, 9});
    tbl.push_back('{0, 1, 0,   0, 0, 0, 1, 0, 0, 2, 9});
    tbl.push_back('{0, 1, 0,   0, 0, 0, 1, 0, 0, 2, 8});
    tbl.push_back('{0, 0, 1, 120, 0, 0, 1, 0, 9, 9, 0});
    tbl.push_back('{0, 1, 1,   5, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1,  12, 0, 0, 1, 0, 1, 2, 0});
    tbl.push_back('{0, 1, 0,   0, 0, 0, 1, 0, 1, 1, 9});
    tbl.push_back('{0, 0, 1,  10, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 0,   0, 0, 0, 1, 0, 0, 9, 9});
    tbl.push_back('{1, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].ld, tbl[i].p, tbl[i].a);
      chk($sformatf("vec%0d_busy", i),    int'(busy),     int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_time_up", i), int'(time_up),  int'(tbl[i].e_tu));
      chk($sformatf("vec%0d_tens", i),    int'(sec_tens), tbl[i].e_tens);
      chk($sformatf("vec%0d_ones", i),    int'(sec_ones), tbl[i].e_ones);
      chk($sformatf("vec%0d_tenths", i),  int'(tenths),   tbl[i].e_tenths);
    end

    // 3 s round, 30 ticks: time_up exactly once, on the 30th tick.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 0, 0);
    tu_cnt = 0; tu_at = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("seq3_digits", shown(), 30 - i);
      if (time_up) begin tu_cnt++; tu_at = i; end
    end
    cyc(0, 0, 0, 0, 0, 0);
    if (time_up) tu_cnt++;
    chk("seq3_tu_count", tu_cnt, 1);
    chk("seq3_tu_at", tu_at, 30);
    chk("seq3_busy_after", int'(busy), 0);

    // Saturated load: 99.0 and 990 ticks to expiry.
    cyc(0, 0, 1, 120, 0, 0);
    chk("sat_digits", shown(), 990);
    n = 0;
    while (n < 1200) begin
      cyc(0, 1, 0, 0, 0, 0);
      n++;
      if (time_up) break;
    end
    chk("sat_ticks", n, 990);

    // Pause holds 01.5; 15 more ticks after release reach expiry.
    cyc(0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 0, 1, 0);
      chk("pause_hold", shown(), 15);
    end
    cyc(0, 0, 0, 0, 0, 0);
    tu_at = -1;
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      if (time_up && tu_at < 0) tu_at = i;
    end
    chk("pause_tu_at", tu_at, 15);

    // Restart mid-round, then abort together with start.
    cyc(0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("restart_pre", shown(), 38);
    cyc(0, 0, 1, 4, 0, 0);
    chk("restart_digits", shown(), 40);
    chk("restart_no_tu", int'(time_up), 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 9, 0, 1);
    chk("abort_digits", shown(), 0);
    chk("abort_busy", int'(busy), 0);
    tu_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      if (time_up) tu_cnt++;
    end
    chk("abort_no_tu", tu_cnt, 0);

    // Zero load expires immediately; reset mid-run clears everything.
    cyc(0, 0, 1, 0, 0, 0);
    chk("zero_tu", int'(time_up), 1);
    chk("zero_busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("zero_tu_once", int'(time_up), 0);
    cyc(0, 0, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("rst_outputs", int'(busy) + int'(time_up) + shown(), 0);

`ifdef ROUND_TIMER_WARN_EN
    // 7 s round: warn rises at 04.9 and clears at expiry.
    cyc(0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("warn_at_5_0", int'(warn), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("warn_at_4_9", int'(warn), 1);
    for (int i = 0; i < 49; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("warn_expiry_tu", int'(time_up), 1);
    chk("warn_expiry", int'(warn), 0);
`endif

    // Randomized traffic against the model.
    cyc(1, 0, 0, 0, 0, 0);
    p_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit r, t, s, a;
      int ld;
      r  = ($urandom_range(0, 299) == 0);
      a  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 1) == 1);
      ld = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
      cyc(r, t, s, ld, p_lvl, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
